// File: rtl/encoder_8_to_3_buf.sv
// encoder_8_to_3_buf
//   Captures active-low 8-bit request vectors, priority-encodes each one
//   (highest active index wins) and buffers the active-low 3-bit codes in a
//   small FIFO for a downstream consumer.
//
// Handshake: a transfer on either side happens at a rising clk edge where
// valid and ready are both 1. in_ready depends only on registered state and
// enable_n. out_valid/code_n/gs_n depend only on registered state. Neither
// ready depends on the opposite side's valid/ready in the same cycle.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   enable_n   active-low enable; 1 = capture nothing (draining continues)
//   req_n[7:0] active-low request lines
//   in_valid   req_n presented for capture
//   in_ready   block can capture this cycle
//   code_n[2:0] active-low index of head entry (3'b111 when empty)
//   gs_n       active-low group select; 0 while a head entry is presented
//   out_valid  head entry available
//   out_ready  consumer accepts head entry
//   ovf        sticky: a non-empty capture attempt was lost to a full buffer
//
// Parameter
//   DEPTH      number of buffered entries (power of two, 2..8)
module encoder_8_to_3_buf #(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable_n,
  input  logic [7:0] req_n,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [2:0] code_n,
  output logic       gs_n,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       ovf
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [2:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          run;
  logic          ovf_q;
  logic          full;
  logic          any_req;
  logic          push;
  logic          pop;
  logic [2:0]    enc_code_n;

  // Priority encoder: later (higher) indices overwrite earlier ones, so the
  // highest active request wins. Stored code is the inverted index.
  always_comb begin
    enc_code_n = 3'b111;
    for (int i = 0; i < 8; i++) begin
      if (!req_n[i]) enc_code_n = ~3'(i);
    end
  end

  assign full     = (count == FULL_CNT);
  assign any_req  = (req_n != 8'hFF);

  // run holds in_ready low during reset and for the first edge after
  // release, so in_ready never combinationally depends on rst_n.
  assign in_ready = run & ~enable_n & ~full;

  // An all-ones vector is a legal capture but produces no entry.
  assign push      = in_valid & in_ready & any_req;
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;

  assign code_n = out_valid ? mem[rd_ptr] : 3'b111;
  assign gs_n   = ~out_valid;
  assign ovf    = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run    <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      run <= 1'b1;

      // DEPTH is a power of two, so natural pointer overflow is the wrap.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // A lost attempt is judged on the pre-edge occupancy: a pop at the
      // same edge does not make room for this cycle's request.
      if (!enable_n && in_valid && full && any_req) ovf_q <= 1'b1;
    end
  end

  // Storage needs no reset: entries are only visible while count > 0.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= enc_code_n;
  end

endmodule

// File: doc/encoder_8_to_3_buf.md
ENCODER_8_TO_3_BUF -- requirements
Module: encoder_8_to_3_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning number of result entries buffered (power of two, 2..8).
REQ-002 SHALL have clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have enable_n  input  1  active-low enable; 1 = block captures nothing.
REQ-005 SHALL have req_n  input  8  active-low request lines; bit i low = request i active.
REQ-006 SHALL have in_valid  input  1  req_n is presented for capture this cycle.
REQ-007 SHALL have in_ready  output  1  block can capture this cycle.
REQ-008 SHALL have code_n  output  3  active-low encoded index of head entry.
REQ-009 SHALL have gs_n  output  1  active-low group-select; 0 = head entry valid and holds a request.
REQ-010 SHALL have out_valid  output  1  head entry available.
REQ-011 SHALL have out_ready  input  1  consumer accepts head entry this cycle.
REQ-012 SHALL have ovf  output  1  sticky flag: a capture attempt was lost because the buffer was full.

Function
REQ-013 SHALL define capture as in_valid=1 and in_ready=1 at a rising edge.
REQ-014 SHALL drive in_ready = (enable_n==0) and (buffer not full), from registered occupancy only; no combinational path from out_ready.
REQ-015 SHALL encode by priority: highest index i with req_n[i]=0 wins; stored code_n = ~i (3 bits).
REQ-016 SHALL discard, not enqueue, a capture whose req_n is 8'hFF; in_ready unaffected.
REQ-017 SHALL enqueue one entry per non-FF capture, in capture order (FIFO).
REQ-018 SHALL define pop as out_valid=1 and out_ready=1 at a rising edge; head advances by one.
REQ-019 SHALL drive out_valid=1 whenever occupancy > 0; latency: capture at edge N into empty buffer -> out_valid=1, code_n valid after edge N.
REQ-020 SHALL drive code_n=3'b111 and gs_n=1 whenever out_valid=0; gs_n=0 whenever out_valid=1.
REQ-021 SHALL hold code_n/gs_n/out_valid stable while out_valid=1 and out_ready=0.
REQ-022 SHALL, on simultaneous capture and pop with occupancy between 1 and DEPTH-1, keep occupancy unchanged and preserve order.
REQ-023 SHALL, when full and popping, keep in_ready=0 that cycle; capture allowed from next cycle.
REQ-024 SHALL set ovf=1 at an edge where enable_n=0, in_valid=1, buffer full and req_n != 8'hFF; ovf stays 1 until reset.
REQ-025 SHALL wrap read/write pointers modulo DEPTH without loss or duplication.
REQ-026 SHALL, when enable_n goes high mid-operation, stop capturing immediately but continue draining stored entries normally.
REQ-027 SHALL ignore req_n and in_valid entirely while enable_n=1 (no capture, no ovf).

Reset
REQ-028 SHALL, while rst_n=0, asynchronously force: buffer empty, pointers 0, out_valid=0, code_n=3'b111, gs_n=1, ovf=0, in_ready=0.
REQ-029 SHALL discard all buffered entries on reset asserted mid-operation; no partial entry survives.
REQ-030 SHALL, after rst_n rises, allow first capture on the first rising edge with in_ready=1.

Verification
REQ-031 SHALL cover: enable_n=0, req_n=8'b1101_0111 captured into empty buffer, out_ready=0 -> next cycle out_valid=1, code_n=3'b010 (index 5), gs_n=0, held until pop.
REQ-032 SHALL cover: captures req_n=8'hFE, 8'hFF, 8'h7F -> exactly two entries, popped in order code_n=3'b111 (index 0) then 3'b000 (index 7).
REQ-033 SHALL cover: DEPTH=2, three captures attempted with out_ready=0 (non-FF) -> in_ready=0 after second, ovf=1 after third, first two entries intact.
REQ-034 SHALL cover: continuous capture and pop every cycle for 20 cycles with rotating single-bit requests -> output sequence equals input sequence, occupancy never exceeds 1, ovf=0.
REQ-035 SHALL cover: two entries buffered, enable_n=1, out_ready=1 -> both entries drain, in_ready=0 throughout, no new entries.
REQ-036 SHALL cover: rst_n pulsed low mid-clock-cycle with full buffer and ovf=1 -> immediately out_valid=0, code_n=3'b111, gs_n=1, ovf=0, in_ready=0.
